fmap_write_arbiter: RTL

Shares the single write port (port A) of the feature-map BRAM between `NREQ` CNN layer writers. The display tiler reads the same BRAM on port B. The block grants one requester at a time in round-robin order and accepts a burst of `len` bytes from it. It writes those bytes to consecutive BRAM addresses starting at the requester's base, then signals completion. It sits between the conv/pool layer output stages and BRAM port A, in the `pix_clk` domain.

---
 rtl/fmap_arb_pkg.sv | 28 ++
 rtl/fmap_rr_pick.sv | 40 ++++
 rtl/fmap_write_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fmap_arb_pkg.sv
// ---------------------------------------------------------------------------
// fmap_arb_pkg
// Shared definitions for the feature-map BRAM write arbiter:
//   - arb_state_e     : arbiter FSM states (IDLE, XFER, DONE)
//   - FMAP_LEN_W      : default burst-length field width in beats
//   - AXI_OK / AXI_ERR: completion status codes shared with the AXI-Lite
//                       side of the codebase (OKAY / SLVERR encoding)
//   - rr_after        : round-robin successor of a requester index
// ---------------------------------------------------------------------------
package fmap_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    localparam int FMAP_LEN_W = 12;

    localparam logic [1:0] AXI_OK  = 2'b00;
    localparam logic [1:0] AXI_ERR = 2'b10;

    // Index that follows 'id' in a ring of 'n' requesters.
    function automatic int rr_after(input int id, input int n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/fmap_rr_pick.sv
// ---------------------------------------------------------------------------
// fmap_rr_pick
// Combinational rotate-priority encoder. Requester rr_ptr has the highest
// priority, then rr_ptr+1, ... wrapping modulo NREQ.
// Ports:
//   req    in  NREQ         : pending request vector
//   rr_ptr in  $clog2(NREQ) : index of the highest-priority requester
//   any    out 1            : at least one request pending
//   winner out $clog2(NREQ) : index of the selected requester (0 if none)
// ---------------------------------------------------------------------------
module fmap_rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             any,
    output logic [IDX_W-1:0] winner
);

    logic             found;
    logic [IDX_W-1:0] idx;

    assign any = |req;

    // Walk the ring starting at rr_ptr; the first pending request wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDX_W'((int'(rr_ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fmap_write_arbiter.sv
// ---------------------------------------------------------------------------
// fmap_write_arbiter
// Shares BRAM port A of the feature-map buffer between NREQ layer writers.
// One requester at a time is granted in round-robin order; its burst of
// req_len bytes is written to consecutive addresses from req_base (address
// arithmetic wraps modulo 2^ADDR_W), then done[gid] pulses for one cycle.
//
// Optional feature: define FMAP_ARB_TIMEOUT_EN to enable the stall timeout.
// A grantee that stalls for TIMEOUT consecutive XFER cycles has its burst
// aborted (remaining beats dropped) with err pulsing alongside done.
// Without the macro err is constant 0 and a stalled grantee keeps the port.
//
// Ports:
//   pix_clk      in  1           : clock
//   periph_reset in  1           : synchronous active-high reset
//   req_valid    in  NREQ        : burst request per requester
//   req_base     in  NREQ*ADDR_W : burst start address, slice i = requester i
//   req_len      in  NREQ*LEN_W  : burst length in beats (0 allowed)
//   req_ready    out NREQ        : one-hot request acknowledge (combinational)
//   wr_valid     in  NREQ        : data beat valid
//   wr_data      in  NREQ*DATA_W : data beat
//   wr_ready     out NREQ        : one-hot beat ready for the grantee
//   done         out NREQ        : one-cycle burst-complete pulse
//   err          out 1           : one-cycle timeout-abort pulse
//   bram_addr    out ADDR_W      : BRAM port A address
//   bram_din     out DATA_W      : BRAM port A write data
//   bram_we      out 1           : BRAM port A write enable
//   busy         out 1           : arbiter not idle
//   grant_id     out $clog2(NREQ): index of the current grantee
// ---------------------------------------------------------------------------
module fmap_write_arbiter
    import fmap_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int LEN_W   = FMAP_LEN_W,
    parameter int TIMEOUT = 255
) (
    input  logic                       pix_clk,
    input  logic                       periph_reset,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*ADDR_W-1:0]     req_base,
    input  logic [NREQ*LEN_W-1:0]      req_len,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0]            wr_valid,
    input  logic [NREQ*DATA_W-1:0]     wr_data,
    output logic [NREQ-1:0]            wr_ready,
    output logic [NREQ-1:0]            done,
    output logic                       err,
    output logic [ADDR_W-1:0]          bram_addr,
    output logic [DATA_W-1:0]          bram_din,
    output logic                       bram_we,
    output logic                       busy,
    output logic [$clog2(NREQ)-1:0]    grant_id
);

    localparam int IDX_W = $clog2(NREQ);

    // ---------------------------------------------------------------
    // Per-requester views of the flattened buses
    // ---------------------------------------------------------------
    logic [ADDR_W-1:0] base_arr [NREQ];
    logic [LEN_W-1:0]  len_arr  [NREQ];
    logic [DATA_W-1:0] data_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign base_arr[gi] = req_base[gi*ADDR_W +: ADDR_W];
            assign len_arr[gi]  = req_len[gi*LEN_W +: LEN_W];
            assign data_arr[gi] = wr_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    arb_state_e        state_reg;
    logic [IDX_W-1:0]  gid_reg;
    logic [IDX_W-1:0]  rr_ptr_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  cnt_reg;
    logic [NREQ-1:0]   wr_ready_reg;
    logic [NREQ-1:0]   done_reg;
    logic              err_reg;
    logic              bram_we_reg;
    logic [ADDR_W-1:0] bram_addr_reg;
    logic [DATA_W-1:0] bram_din_reg;

    // ---------------------------------------------------------------
    // Round-robin selection
    // ---------------------------------------------------------------
    logic             pick_any;
    logic [IDX_W-1:0] pick_winner;

    fmap_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr_reg),
        .any    (pick_any),
        .winner (pick_winner)
    );

    logic grant_now;
    assign grant_now = (state_reg == ST_IDLE) && pick_any && !periph_reset;

    // Acknowledge is combinational so the requester sees it in the same
    // cycle the grant is latched; suppressed while reset is asserted
    // because no grant is taken in that cycle.
    always_comb begin
        req_ready = '0;
        if (grant_now) begin
            req_ready[pick_winner] = 1'b1;
        end
    end

    logic beat_acc;
    logic last_beat;
    assign beat_acc  = (state_reg == ST_XFER) && wr_valid[gid_reg];
    assign last_beat = (cnt_reg == (len_reg - LEN_W'(1)));

    // ---------------------------------------------------------------
    // Optional stall timeout
    // ---------------------------------------------------------------
    logic stall_hit;

`ifdef FMAP_ARB_TIMEOUT_EN
    localparam int STALL_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [STALL_W-1:0] stall_reg;

    // The TIMEOUT-th consecutive idle XFER cycle is the one that aborts.
    assign stall_hit = (state_reg == ST_XFER) && !beat_acc &&
                       (stall_reg == STALL_W'(TIMEOUT - 1));

    always_ff @(posedge pix_clk) begin
        if (periph_reset) begin
            stall_reg <= '0;
        end else if ((state_reg != ST_XFER) || beat_acc) begin
            stall_reg <= '0;
        end else begin
            stall_reg <= stall_reg + 1'b1;
        end
    end
`else
    assign stall_hit = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Arbiter FSM with registered outputs
    // ---------------------------------------------------------------
    always_ff @(posedge pix_clk) begin
        if (periph_reset) begin
            state_reg     <= ST_IDLE;
            gid_reg       <= '0;
            rr_ptr_reg    <= '0;
            base_reg      <= '0;
            len_reg       <= '0;
            cnt_reg       <= '0;
            wr_ready_reg  <= '0;
            done_reg      <= '0;
            err_reg       <= 1'b0;
            bram_we_reg   <= 1'b0;
            bram_addr_reg <= '0;
            bram_din_reg  <= '0;
        end else begin
            // Pulsed outputs default low; the address/data hold.
            bram_we_reg <= 1'b0;
            done_reg    <= '0;
            err_reg     <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (pick_any) begin
                        gid_reg  <= pick_winner;
                        base_reg <= base_arr[pick_winner];
                        len_reg  <= len_arr[pick_winner];
                        cnt_reg  <= '0;
                        if (len_arr[pick_winner] != '0) begin
                            state_reg    <= ST_XFER;
                            wr_ready_reg <= NREQ'(1) << pick_winner;
                        end else begin
                            // Zero-length burst: straight to completion.
                            state_reg <= ST_DONE;
                            done_reg  <= NREQ'(1) << pick_winner;
                        end
                    end
                end

                ST_XFER: begin
                    if (beat_acc) begin
                        bram_we_reg   <= 1'b1;
                        bram_addr_reg <= base_reg + ADDR_W'(cnt_reg);
                        bram_din_reg  <= data_arr[gid_reg];
                        cnt_reg       <= cnt_reg + 1'b1;
                        if (last_beat) begin
                            // The final write lands in the DONE cycle.
                            state_reg    <= ST_DONE;
                            wr_ready_reg <= '0;
                            done_reg     <= NREQ'(1) << gid_reg;
                        end
                    end else if (stall_hit) begin
                        state_reg    <= ST_DONE;
                        wr_ready_reg <= '0;
                        done_reg     <= NREQ'(1) << gid_reg;
                        err_reg      <= 1'b1;
                    end
                end

                ST_DONE: begin
                    rr_ptr_reg <= IDX_W'(rr_after(int'(gid_reg), NREQ));
                    state_reg  <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_ready  = wr_ready_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign bram_we   = bram_we_reg;
    assign bram_addr = bram_addr_reg;
    assign bram_din  = bram_din_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign grant_id  = gid_reg;

endmodule
